// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the quad-capable SPI receive front end.
// Lane encodings, word widths, the FIFO payload record and FSM states.
package spi_rx_pkg;

    localparam logic [1:0] LANES_1 = 2'b00;
    localparam logic [1:0] LANES_2 = 2'b01;
    localparam logic [1:0] LANES_4 = 2'b10;

    localparam logic [5:0] W16 = 6'd16;
    localparam logic [5:0] W32 = 6'd32;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
    } rx_word_t;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'b00,
        ST_IDLE      = 2'b01,
        ST_SHIFT     = 2'b10
    } rx_state_t;

    // Bits delivered per sclk rise; the reserved encoding behaves as one lane.
    function automatic logic [5:0] lane_count(input logic [1:0] lanes);
        logic [5:0] n;
        case (lanes)
            LANES_1: n = 6'd1;
            LANES_2: n = 6'd2;
            LANES_4: n = 6'd4;
            default: n = 6'd1;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lanes);
        logic [3:0] m;
        case (lanes)
            LANES_1: m = 4'b0001;
            LANES_2: m = 4'b0011;
            LANES_4: m = 4'b1111;
            default: m = 4'b0001;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Valid/ready word stream from the SPI receiver to the command decoder.
interface spi_slave_rx_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_first;

    modport master (output m_valid, output m_data, output m_first, input m_ready);
    modport slave  (input m_valid, input m_data, input m_first, output m_ready);
endinterface

// File: rtl/spi_rx_fifo.sv
// First-word fall-through word FIFO; a pop frees a slot for a same-cycle push
// even when full. Storage is reset so the head reads zero out of reset.
module spi_rx_fifo
    import spi_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rx_word_t push_data,
    output logic     full,
    input  logic     pop,
    output rx_word_t pop_data,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    rx_word_t      mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only 1/2/4-lane SPI slave: oversamples the pins, assembles 16/32-bit
// words LSB-first and hands them to the decoder through a small FIFO.
module spi_slave_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic [3:0]            mosi,
    input  logic [1:0]            cfg_lanes,
    input  logic                  cfg_dword,
    spi_slave_rx_if.master        m_if,
    input  logic                  err_clr,
    output logic                  ovf_err,
    output logic                  frame_err,
    output logic                  busy
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [3:0]             mosi_sync_q [SYNC_STAGES];
    logic                   sclk_dly_q;
    logic                   sclk_s;
    logic                   cs_n_s;
    logic [3:0]             mosi_s;
    logic                   rise_s;

    rx_state_t   state_q;
    rx_state_t   state_d;
    logic [1:0]  lanes_q;
    logic [1:0]  lanes_d;
    logic        dword_q;
    logic        dword_d;
    logic [31:0] shreg_q;
    logic [31:0] shreg_d;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;
    logic        first_q;
    logic        first_d;
    logic        frame_err_q;
    logic        frame_err_d;
    logic        ovf_err_q;
    logic        ovf_err_d;

    logic [5:0]  cnt_add_s;
    logic [5:0]  word_w_s;
    logic [31:0] shreg_sh_s;
    logic        push_s;
    rx_word_t    push_word_s;
    rx_word_t    head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        drop_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise_s = sclk_s & ~sclk_dly_q;

    // Pin synchronizers. cs_n resets to "selected" so that WAIT_IDLE only
    // leaves once a genuine deselect has propagated through the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= 4'd0;
            end
        end else begin
            sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_dly_q     <= sclk_s;
            mosi_sync_q[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_n_s) state_d = ST_IDLE;
                else        state_d = ST_WAIT_IDLE;
            end
            ST_IDLE: begin
                if (!cs_n_s) state_d = ST_SHIFT;
                else         state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cs_n_s) state_d = ST_IDLE;
                else        state_d = ST_SHIFT;
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    assign cnt_add_s  = cnt_q + lane_count(lanes_q);
    assign word_w_s   = dword_q ? W32 : W16;
    assign shreg_sh_s = shreg_q | ({28'd0, mosi_s & lane_mask(lanes_q)} << cnt_q[4:0]);

    // FSM output logic: word assembly, push and frame error.
    always_comb begin
        lanes_d     = lanes_q;
        dword_d     = dword_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        frame_err_d = 1'b0;
        push_s      = 1'b0;
        push_word_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (!cs_n_s) begin
                    lanes_d = cfg_lanes;
                    dword_d = cfg_dword;
                    shreg_d = 32'd0;
                    cnt_d   = 6'd0;
                    first_d = 1'b1;
                end else begin
                    first_d = first_q;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    if (cnt_add_s == word_w_s) begin
                        push_s            = 1'b1;
                        push_word_s.data  = dword_q ? shreg_sh_s : {16'd0, shreg_sh_s[15:0]};
                        push_word_s.first = first_q;
                        shreg_d           = 32'd0;
                        cnt_d             = 6'd0;
                        first_d           = 1'b0;
                    end else begin
                        shreg_d = shreg_sh_s;
                        cnt_d   = cnt_add_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // A word completing on the deselect cycle has already been pushed.
                if (cs_n_s) begin
                    frame_err_d = (cnt_d != 6'd0);
                    cnt_d       = 6'd0;
                    shreg_d     = 32'd0;
                end else begin
                    frame_err_d = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign drop_s = push_s & fifo_full_s & ~m_if.m_ready;

    // Overflow flag: a new drop outranks a same-cycle clear.
    always_comb begin
        ovf_err_d = ovf_err_q;
        if (drop_s) begin
            ovf_err_d = 1'b1;
        end else if (err_clr) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q     <= LANES_1;
            dword_q     <= 1'b0;
            shreg_q     <= 32'd0;
            cnt_q       <= 6'd0;
            first_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            lanes_q     <= lanes_d;
            dword_q     <= dword_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    spi_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_word_s),
        .full      (fifo_full_s),
        .pop       (m_if.m_ready),
        .pop_data  (head_s),
        .empty     (fifo_empty_s)
    );

    assign m_if.m_valid = ~fifo_empty_s;
    assign m_if.m_data  = head_s.data;
    assign m_if.m_first = head_s.first;
    assign ovf_err      = ovf_err_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a vector table of single frames plus
// hand-written burst, overflow and reset-mid-frame sequences.
module tb_spi_slave_rx;
    import spi_rx_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] mosi = 4'd0;
    logic [1:0] cfg_lanes = 2'b00;
    logic       cfg_dword = 1'b0;
    logic       err_clr = 1'b0;
    logic       ovf_err;
    logic       frame_err;
    logic       busy;

    spi_slave_rx_if sif ();

    spi_slave_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .cfg_lanes (cfg_lanes),
        .cfg_dword (cfg_dword),
        .m_if      (sif),
        .err_clr   (err_clr),
        .ovf_err   (ovf_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    logic [32:0] rx_q[$];

    always @(negedge clk) begin
        if (sif.m_valid && sif.m_ready) rx_q.push_back({sif.m_first, sif.m_data});
        if (frame_err) fe_cnt++;
    end

    typedef struct {
        logic [1:0]  lanes;
        logic        dword;
        logic [31:0] data;
        int          nr;
        int          exp_words;
        logic [31:0] exp_data;
        int          exp_fe;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_fall(input logic [1:0] lanes, input logic dword);
        cfg_lanes = lanes;
        cfg_dword = dword;
        tick(1);
        cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_rise();
        tick(HALF);
        cs_n = 1'b1;
        tick(8);
    endtask

    // Unused lanes are driven high so a missing lane mask shows up in the data.
    task automatic send(input logic [1:0] lanes, input logic [31:0] data, input int nr,
                        output int lat);
        int          L;
        logic [3:0]  m;
        logic [31:0] sh;
        L   = (lanes == 2'b01) ? 2 : (lanes == 2'b10) ? 4 : 1;
        m   = (L == 4) ? 4'hF : (L == 2) ? 4'h3 : 4'h1;
        lat = 0;
        for (int i = 0; i < nr; i++) begin
            sh   = data >> (i * L);
            mosi = (sh[3:0] & m) | ~m;
            tick(HALF);
            sclk = 1'b1;
            if (i == nr - 1) begin
                for (int k = 1; k <= 8; k++) begin
                    @(negedge clk);
                    if (sif.m_valid && lat == 0) lat = k;
                end
                tick(1);
            end else begin
                tick(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        int base;
        int fb;
        int lat;
        int got;

        vt[0] = '{2'b10, 1'b0, 32'h0000A5C3, 4,  1, 32'h0000A5C3, 0};
        vt[1] = '{2'b00, 1'b1, 32'hDEADBEEF, 32, 1, 32'hDEADBEEF, 0};
        vt[2] = '{2'b01, 1'b0, 32'h00001234, 8,  1, 32'h00001234, 0};
        vt[3] = '{2'b10, 1'b1, 32'h0BADF00D, 3,  0, 32'h00000000, 1};
        vt[4] = '{2'b10, 1'b1, 32'h0BADF00D, 8,  1, 32'h0BADF00D, 0};
        vt[5] = '{2'b11, 1'b0, 32'h00008001, 16, 1, 32'h00008001, 0};
        vt[6] = '{2'b01, 1'b1, 32'h13579BDF, 16, 1, 32'h13579BDF, 0};
        vt[7] = '{2'b10, 1'b0, 32'h0000FFFF, 2,  0, 32'h00000000, 1};

        sif.m_ready = 1'b1;
        tick(3);
        chk("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
        chk("rst_m_data", sif.m_data, 32'd0);
        chk("rst_m_first", {31'd0, sif.m_first}, 32'd0);
        chk("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < 8; v++) begin
            base = rx_q.size();
            fb   = fe_cnt;
            cs_fall(vt[v].lanes, vt[v].dword);
            send(vt[v].lanes, vt[v].data, vt[v].nr, lat);
            cs_rise();
            got = rx_q.size() - base;
            chk($sformatf("v%0d_words", v), got, vt[v].exp_words);
            chk($sformatf("v%0d_frame_err", v), fe_cnt - fb, vt[v].exp_fe);
            chk($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
            if (vt[v].exp_words == 1 && got >= 1) begin
                chk($sformatf("v%0d_data", v), rx_q[base][31:0], vt[v].exp_data);
                chk($sformatf("v%0d_first", v), {31'd0, rx_q[base][32]}, 32'd1);
                chk($sformatf("v%0d_latency_ok", v), {31'd0, (lat >= 1 && lat <= SYNC + 2)}, 32'd1);
            end
        end

        // Burst of two 2-lane 16-bit words inside one frame.
        base = rx_q.size();
        fb   = fe_cnt;
        cs_fall(2'b01, 1'b0);
        send(2'b01, 32'h1234, 8, lat);
        tick(2);
        chk("burst_busy_mid", {31'd0, busy}, 32'd1);
        send(2'b01, 32'h5678, 8, lat);
        tick(2);
        chk("burst_busy_end", {31'd0, busy}, 32'd1);
        cs_rise();
        chk("burst_busy_idle", {31'd0, busy}, 32'd0);
        chk("burst_words", rx_q.size() - base, 32'd2);
        chk("burst_frame_err", fe_cnt - fb, 32'd0);
        if (rx_q.size() - base >= 2) begin
            chk("burst_w0_data", rx_q[base][31:0], 32'h00001234);
            chk("burst_w0_first", {31'd0, rx_q[base][32]}, 32'd1);
            chk("burst_w1_data", rx_q[base+1][31:0], 32'h00005678);
            chk("burst_w1_first", {31'd0, rx_q[base+1][32]}, 32'd0);
        end

        // Overflow: five words into a four-entry FIFO with the consumer stalled.
        sif.m_ready = 1'b0;
        tick(1);
        base = rx_q.size();
        cs_fall(2'b10, 1'b0);
        for (int w = 1; w <= 5; w++) send(2'b10, w, 4, lat);
        cs_rise();
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        chk("ovf_head_valid", {31'd0, sif.m_valid}, 32'd1);
        chk("ovf_head_data", sif.m_data, 32'd1);
        chk("ovf_head_first", {31'd0, sif.m_first}, 32'd1);
        sif.m_ready = 1'b1;
        tick(8);
        chk("ovf_drain_count", rx_q.size() - base, 32'd4);
        if (rx_q.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_w%0d_data", i), rx_q[base+i][31:0], i + 1);
                chk($sformatf("ovf_w%0d_first", i), {31'd0, rx_q[base+i][32]}, (i == 0) ? 32'd1 : 32'd0);
            end
        end
        chk("ovf_empty", {31'd0, sif.m_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf_err}, 32'd0);

        // Reset asserted mid-frame and released while still selected.
        base = rx_q.size();
        fb   = fe_cnt;
        cs_fall(2'b10, 1'b0);
        send(2'b10, 32'h00000021, 2, lat);
        tick(2);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, sif.m_valid}, 32'd0);
        rst_n = 1'b1;
        tick(4);
        send(2'b10, 32'h00000043, 2, lat);
        tick(2);
        chk("midrst_not_busy", {31'd0, busy}, 32'd0);
        cs_rise();
        chk("midrst_words", rx_q.size() - base, 32'd0);
        chk("midrst_frame_err", fe_cnt - fb, 32'd0);
        cs_fall(2'b10, 1'b0);
        send(2'b10, 32'h0000FFFF, 4, lat);
        cs_rise();
        chk("postrst_words", rx_q.size() - base, 32'd1);
        if (rx_q.size() - base >= 1) begin
            chk("postrst_data", rx_q[base][31:0], 32'h0000FFFF);
            chk("postrst_first", {31'd0, rx_q[base][32]}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Receive-only quad-capable SPI slave front end of the crypto accelerator. It sits directly downstream of the SPI pins and accepts the 16- or 32-bit words the host drives on 1, 2 or 4 MOSI lanes. It oversamples SCLK/CS_n/MOSI in the system clock domain and assembles words LSB-first. Completed words are delivered through a small FIFO to the register/command decoder over a valid/ready interface.

Parameters:
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (min 2)
FIFO_DEPTH, 4, output word FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
sclk  input  1  SPI clock from pin, idle low, async to clk
cs_n  input  1  SPI chip select from pin, active-low
mosi  input  4  SPI data lanes; lane i carries bit (base+i)
cfg_lanes  input  2  00=1 lane, 01=2 lanes, 10=4 lanes, 11 reserved (treated as 1 lane)
cfg_dword  input  1  0=16-bit words, 1=32-bit words
m_valid  output  1  FIFO head word valid
m_ready  input  1  consumer accepts head word
m_data  output  32  received word; bits [31:16] zero for 16-bit words
m_first  output  1  head word is the first word after a cs_n fall
err_clr  input  1  clears ovf_err
ovf_err  output  1  sticky: word dropped because FIFO was full
frame_err  output  1  one-clk pulse: cs_n rose with a partial word
busy  output  1  cs_n (synced) low and frame in progress

Behaviour:
- Reset values: m_valid=0, m_data=0, m_first=0, ovf_err=0, frame_err=0, busy=0. FIFO is empty. State is WAIT_IDLE.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops. rise = sclk_s & ~sclk_s_d. mosi is sampled from the synced copy in the cycle rise is detected.
- Timing requirement: sclk high and low phases each >= SYNC_STAGES+1 clk periods. MOSI must be stable from half a period before each rising edge.
- FSM:
  - WAIT_IDLE: wait for cs_n_s=1, then go to IDLE. Reset always enters WAIT_IDLE, so a reset with cs_n low never captures a partial frame.
  - IDLE: on cs_n_s fall, latch cfg_lanes/cfg_dword into lanes_q/dword_q, clear shreg and cnt, set first_q=1, go to SHIFT. cfg changes during a frame are ignored.
  - SHIFT: on each rise, shreg[cnt +: L] <= mosi_s[L-1:0] and cnt <= cnt+L, where L is 1, 2 or 4.
  - Word complete: when the new cnt equals W (16 or 32), push {zero-extended shreg, first_q} into the FIFO. Then cnt=0 and first_q=0, and the FSM stays in SHIFT (burst: cs_n held low).
  - On cs_n_s rise: go to IDLE. If cnt!=0, pulse frame_err and discard the partial word.
- Edge counts per word: 16-bit needs 16/8/4 rises for 1/2/4 lanes; 32-bit needs 32/16/8.
- Latency: m_valid rises 1 clk after the rise-detect cycle of the completing edge. That is SYNC_STAGES+2 clk after the pin edge when the FIFO is empty.
- FIFO: first-word fall-through; m_data/m_first/m_valid reflect the head entry.
  - Pop on m_valid & m_ready.
  - Push and pop in the same cycle are both allowed in any state; when full, the simultaneous pop frees the slot and the push succeeds.
  - Push while full without a pop: the word is dropped and ovf_err is set.
- ovf_err: sticky until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- busy = state==SHIFT.
- cs_n rise and a completing rise in the same clk: the word is pushed first, no frame_err, then the FSM goes to IDLE.

Decomposition:
- Package spi_rx_pkg holds:
  - lane encoding constants LANES_1/2/4 and lane_count() function
  - word width constants W16=16, W32=32
  - typedef rx_word_t {logic [31:0] data; logic first;}
- One sub-module, spi_rx_fifo (parameter DEPTH, rx_word_t payload, push/full/pop/empty). It is instantiated once.

Test Plan:
- 4 lanes, 16-bit, host sends 0xA5C3 -> exactly 4 sclk rises; one word m_data=0x0000A5C3, m_first=1, no errors.
- 1 lane, 32-bit, 0xDEADBEEF at sclk half period = 4 clk -> m_data=0xDEADBEEF, m_first=1, m_valid within SYNC_STAGES+2 clk of the 32nd rise.
- 2 lanes, 16-bit burst of 0x1234 then 0x5678 with cs_n held low -> two words; m_first=1 then 0; busy stays high until cs_n rises.
- 4 lanes, 32-bit, cs_n raised after 3 rises -> frame_err pulses once, no word pushed. The next full frame of 0x0BADF00D is received correctly.
- m_ready=0, five 16-bit words 0x0001..0x0005 -> FIFO holds 0x0001..0x0004, ovf_err=1. Draining yields 4 words in order; err_clr clears ovf_err.
- rst_n asserted mid-frame with cs_n low, released while cs_n still low, 2 more rises, then cs_n high -> no word, no frame_err. The next frame with 0xFFFF is received.
